// File: rtl/fib_defs.sv
// Shared definitions for the Fibonacci FSMD family (forward and inverse units).
// Provides the default widths, the iteration cap and the common state encoding.
package fib_defs;

    localparam int DEF_F_W     = 20;  // width of a Fibonacci value
    localparam int DEF_I_W     = 5;   // width of a Fibonacci index
    localparam int DEF_MAX_IDX = 30;  // fib(31) = 1346269 exceeds any 20-bit value

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : fib_defs

// File: rtl/fib_inv_amisha.sv
// Inverse-Fibonacci FSMD: returns the largest n with fib(n) <= f plus an
// exact-match flag. Uses the start/ready/done_tick handshake of the forward unit.
//
// Ports:
//   clk_amisha        in   clock, rising edge
//   reset_amisha      in   asynchronous active-high reset
//   start_amisha      in   request, sampled only while idle
//   f_in_amisha       in   value to invert, captured on the accepted start
//   ready_amisha      out  high only while idle
//   done_tick_amisha  out  one-cycle completion pulse
//   i_amisha          out  result index n
//   exact_amisha      out  1 when fib(n) == f
module fib_inv_amisha
    import fib_defs::*;
#(
    parameter int F_W     = DEF_F_W,
    parameter int I_W     = DEF_I_W,
    parameter int MAX_IDX = DEF_MAX_IDX
) (
    input  logic           clk_amisha,
    input  logic           reset_amisha,
    input  logic           start_amisha,
    input  logic [F_W-1:0] f_in_amisha,
    output logic           ready_amisha,
    output logic           done_tick_amisha,
    output logic [I_W-1:0] i_amisha,
    output logic           exact_amisha
);

    state_t         state_r, state_s;
    logic [F_W-1:0] f_r, f_s;
    logic [F_W:0]   t0_r, t0_s;      // fib(n)
    logic [F_W:0]   t1_r, t1_s;      // fib(n+1), one bit wider so fib(31) does not wrap
    logic [I_W-1:0] n_r, n_s;
    logic [I_W-1:0] i_r, i_s;
    logic           exact_r, exact_s;
    logic           ready_r, done_r;
    logic           stop_s;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state_r <= IDLE;
            f_r     <= '0;
            t0_r    <= '0;
            t1_r    <= '0;
            n_r     <= '0;
            i_r     <= '0;
            exact_r <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            f_r     <= f_s;
            t0_r    <= t0_s;
            t1_r    <= t1_s;
            n_r     <= n_s;
            i_r     <= i_s;
            exact_r <= exact_s;
            // Handshake outputs are registered from the next state so they
            // line up exactly with the state they describe.
            ready_r <= (state_s == IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Termination test: the next Fibonacci number already exceeds f, or the cap is hit.
    always_comb begin
        stop_s = (t1_r > {1'b0, f_r}) || (n_r == I_W'(MAX_IDX));
    end

    // Next-state and datapath logic.
    always_comb begin
        state_s = state_r;
        f_s     = f_r;
        t0_s    = t0_r;
        t1_s    = t1_r;
        n_s     = n_r;
        i_s     = i_r;
        exact_s = exact_r;
        case (state_r)
            IDLE: begin
                if (start_amisha) begin
                    f_s     = f_in_amisha;
                    t0_s    = '0;
                    t1_s    = {{F_W{1'b0}}, 1'b1};
                    n_s     = '0;
                    state_s = OP;
                end else begin
                    state_s = IDLE;
                end
            end
            OP: begin
                if (stop_s) begin
                    i_s     = n_r;
                    exact_s = (t0_r == {1'b0, f_r});
                    state_s = DONE;
                end else begin
                    t0_s = t1_r;
                    t1_s = t0_r + t1_r;
                    n_s  = n_r + {{(I_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign ready_amisha     = ready_r;
    assign done_tick_amisha = done_r;
    assign i_amisha         = i_r;
    assign exact_amisha     = exact_r;

endmodule : fib_inv_amisha

// File: tb/tb_fib_inv_amisha.sv
// Scoreboard testbench for fib_inv_amisha: directed vectors plus an index
// round-trip using a bench-side Fibonacci function.
module tb_fib_inv_amisha;

    logic        clk;
    logic        reset;
    logic        start;
    logic [19:0] f_in;
    logic        ready;
    logic        done_tick;
    logic [4:0]  i_out;
    logic        exact;

    typedef struct {
        int i;
        int ex;
        int lat;
        int k;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   held_i = 0;
    int   held_x = 0;
    logic prev_done = 1'b0;

    fib_inv_amisha dut (
        .clk_amisha       (clk),
        .reset_amisha     (reset),
        .start_amisha     (start),
        .f_in_amisha      (f_in),
        .ready_amisha     (ready),
        .done_tick_amisha (done_tick),
        .i_amisha         (i_out),
        .exact_amisha     (exact)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int fib(input int k);
        int a = 0;
        int b = 1;
        int t;
        for (int j = 0; j < k; j++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Monitor: pops the scoreboard on every done_tick and checks output holding otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            held_i    = 0;
            held_x    = 0;
            prev_done = 1'b0;
        end else begin
            if (done_tick) begin
                chk("done_pulse_width", int'(prev_done), 0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done_tick, expected none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("result_i", int'(i_out), e.i);
                    chk("result_exact", int'(exact), e.ex);
                    chk("latency", cyc - e.k, e.lat);
                    held_i = e.i;
                    held_x = e.ex;
                end
            end else begin
                chk("hold_i", int'(i_out), held_i);
                chk("hold_exact", int'(exact), held_x);
            end
            prev_done = done_tick;
        end
    end

    // Wait (bounded) for ready at a falling edge.
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", int'(ready), 1);
    endtask

    // Issue one request and push its expected result. Leaves start low.
    task automatic issue(input int f, input int exp_i, input int exp_x);
        exp_t e;
        wait_ready();
        start = 1'b1;
        f_in  = f[19:0];
        @(posedge clk);
        #1;
        e.i = exp_i; e.ex = exp_x; e.lat = exp_i + 1; e.k = cyc;
        sb.push_back(e);
        @(negedge clk);
        chk("ready_drops", int'(ready), 0);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        exp_t e;
        int   n;
        reset = 1'b1;
        start = 1'b0;
        f_in  = 20'd0;
        #100;
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done_tick), 0);
        chk("rst_i", int'(i_out), 0);
        chk("rst_exact", int'(exact), 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors with hand-computed results.
        issue(0, 0, 1);
        issue(1, 2, 1);
        issue(21, 8, 1);
        issue(20, 7, 0);
        issue(832040, 30, 1);
        issue(1048575, 30, 0);
        // Wait for the slowest case and confirm fib(31) held without wrap.
        n = 0;
        while (!done_tick && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t1_no_wrap", int'(dut.t1_r), 1346269);
        drain();

        // Start and f_in changes during OP are ignored; held start is re-accepted after DONE.
        wait_ready();
        start = 1'b1;
        f_in  = 20'd21;
        @(posedge clk);
        #1;
        e.i = 8; e.ex = 1; e.lat = 9; e.k = cyc;
        sb.push_back(e);
        @(negedge clk);
        f_in = 20'd5;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reaccept_ready", int'(ready), 1);
        @(posedge clk);
        #1;
        e.i = 5; e.ex = 1; e.lat = 6; e.k = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Leave a nonzero result, then abort a long request asynchronously.
        issue(1048575, 30, 0);
        drain();
        issue(832040, 30, 1);
        repeat (9) @(negedge clk);
        #3;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("abort_i", int'(i_out), 0);
        chk("abort_exact", int'(exact), 0);
        chk("abort_ready", int'(ready), 1);
        chk("abort_done", int'(done_tick), 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_abort_ready", int'(ready), 1);

        // Round trip: fib(i) must invert back to i (i = 1 gives 2 because fib(1) = fib(2)).
        for (int k = 0; k <= 30; k++) begin
            issue(fib(k), (k == 1) ? 2 : k, 1);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fib_inv_amisha
